// File: rtl/cla_pipe_addsub_if.sv
// Handshake bundle for cla_pipe_addsub: operand side (in_*) and result side (out_*).
// slave = the adder; master = the producer/consumer driving it.
interface cla_pipe_addsub_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic             op_sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;
  logic             zero;

  modport slave (
    input  in_valid, op_sub, a, b, c_in, out_ready,
    output in_ready, out_valid, sum, c_out, ovf, zero
  );

  modport master (
    output in_valid, op_sub, a, b, c_in, out_ready,
    input  in_ready, out_valid, sum, c_out, ovf, zero
  );
endinterface

// File: rtl/cla_pipe_addsub.sv
// Pipelined add/sub built from 4-bit CLA groups, WIDTH/STAGES result bits per stage.
// Ports: clk, rst_n (async, active low), bus (slave: valid/ready in, valid/ready out, flags).
module cla_pipe_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  cla_pipe_addsub_if.slave bus
);
  localparam int SW  = WIDTH / STAGES;
  localparam int NG  = SW / 4;
  localparam int MSB = WIDTH - 1;
  localparam int L   = STAGES - 1;

  typedef struct packed {
    logic             v;
    logic             c;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
  } stage_t;

  function automatic logic [SW:0] cla_slice(
    input logic [SW-1:0] x,
    input logic [SW-1:0] y,
    input logic          cin
  );
    logic [SW-1:0] g;
    logic [SW-1:0] p;
    logic [SW-1:0] s;
    logic [NG-1:0] gg;
    logic [NG-1:0] gp;
    logic [NG:0]   cg;
    logic [3:0]    cb;
    logic          t;
    g = x & y;
    p = x ^ y;
    for (int j = 0; j < NG; j++) begin
      gg[j] = g[4*j+3]
            | (p[4*j+3] & g[4*j+2])
            | (p[4*j+3] & p[4*j+2] & g[4*j+1])
            | ((&p[4*j+1 +: 3]) & g[4*j]);
      gp[j] = &p[4*j +: 4];
    end
    // Group carries as flat sum-of-products over group G/P.
    cg[0] = cin;
    for (int j = 0; j < NG; j++) begin
      t = cin;
      for (int m = 0; m <= j; m++) t = t & gp[m];
      cg[j+1] = t;
      for (int i = 0; i <= j; i++) begin
        t = gg[i];
        for (int m = i + 1; m <= j; m++) t = t & gp[m];
        cg[j+1] = cg[j+1] | t;
      end
    end
    for (int j = 0; j < NG; j++) begin
      cb[0] = cg[j];
      cb[1] = g[4*j]
            | (p[4*j] & cg[j]);
      cb[2] = g[4*j+1]
            | (p[4*j+1] & g[4*j])
            | (p[4*j+1] & p[4*j] & cg[j]);
      cb[3] = g[4*j+2]
            | (p[4*j+2] & g[4*j+1])
            | (p[4*j+2] & p[4*j+1] & g[4*j])
            | (p[4*j+2] & p[4*j+1] & p[4*j] & cg[j]);
      s[4*j +: 4] = p[4*j +: 4] ^ cb;
    end
    return {cg[NG], s};
  endfunction

  stage_t      st_in [STAGES];
  stage_t      st_nx [STAGES];
  stage_t      st_q  [STAGES];
  logic [SW:0] res   [STAGES];
  logic        advance;
  logic        ovf_nx;
  logic        zero_nx;
  logic        ovf_q;
  logic        zero_q;

  assign advance      = !st_q[L].v || bus.out_ready;
  assign bus.in_ready = advance;

  always_comb begin
    // Subtract runs as a + ~b + ~c_in, so c_in becomes a borrow.
    st_in[0].v = bus.in_valid;
    st_in[0].c = bus.c_in ^ bus.op_sub;
    st_in[0].a = bus.a;
    st_in[0].b = bus.op_sub ? ~bus.b : bus.b;
    st_in[0].s = '0;
    for (int k = 1; k < STAGES; k++) begin
      st_in[k] = st_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      res[k] = cla_slice(st_in[k].a[k*SW +: SW],
                         st_in[k].b[k*SW +: SW],
                         st_in[k].c);
      st_nx[k] = st_in[k];
      st_nx[k].s[k*SW +: SW] = res[k][SW-1:0];
      st_nx[k].c = res[k][SW];
    end
    ovf_nx  = (st_in[L].a[MSB] == st_in[L].b[MSB])
           && (st_nx[L].s[MSB] != st_in[L].a[MSB]);
    zero_nx = (st_nx[L].s == '0);
  end

  // Data only loads behind a valid op so held results and flags stay put.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) st_q[k] <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        if (st_in[k].v) st_q[k] <= st_nx[k];
        else            st_q[k].v <= 1'b0;
      end
      if (st_in[L].v) begin
        ovf_q  <= ovf_nx;
        zero_q <= zero_nx;
      end
    end
  end

  assign bus.out_valid = st_q[L].v;
  assign bus.sum       = st_q[L].s;
  assign bus.c_out     = st_q[L].c;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Directed bench for cla_pipe_addsub, WIDTH=32 STAGES=2.
// Hand-computed vectors, one task per scenario.
module tb_cla_pipe_addsub;
  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  cla_pipe_addsub_if #(.WIDTH(32)) bus ();

  cla_pipe_addsub #(.WIDTH(32), .STAGES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  logic        bb_op  [8] = '{0, 0, 1, 0, 1, 0, 1, 0};
  logic [31:0] bb_a   [8] = '{32'h1, 32'h12345678, 32'h100, 32'hFFFF0000,
                              32'h0, 32'hAAAAAAAA, 32'hA, 32'h0000FFFF};
  logic [31:0] bb_b   [8] = '{32'h2, 32'h11111111, 32'h1, 32'h00010000,
                              32'h1, 32'h55555555, 32'h3, 32'h0000FFFF};
  logic        bb_ci  [8] = '{0, 0, 0, 0, 0, 1, 1, 0};
  logic [31:0] bb_s   [8] = '{32'h3, 32'h23456789, 32'hFF, 32'h0,
                              32'hFFFFFFFF, 32'h0, 32'h6, 32'h0001FFFE};
  logic        bb_co  [8] = '{0, 0, 1, 1, 0, 1, 1, 0};

  task automatic send(input logic op, input logic [31:0] a,
                      input logic [31:0] b, input logic ci);
    bus.in_valid = 1'b1;
    bus.op_sub   = op;
    bus.a        = a;
    bus.b        = b;
    bus.c_in     = ci;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rst out_valid got %b want 0", bus.out_valid); end
    tests++; if (bus.sum !== 32'h0) begin fails++; $display("FAIL rst sum got %h want 0", bus.sum); end
    tests++; if ({bus.c_out, bus.ovf, bus.zero} !== 3'b000) begin fails++; $display("FAIL rst flags got %b want 000", {bus.c_out, bus.ovf, bus.zero}); end
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL rst in_ready got %b want 1", bus.in_ready); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL post_rst in_ready got %b want 1", bus.in_ready); end
  endtask

  task automatic test_add;
    send(1'b0, 32'hFFFFFFFF, 32'h1, 1'b0);
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL add_lat out_valid got %b want 0", bus.out_valid); end
    @(posedge clk); #1;
    tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL add_wrap out_valid got %b want 1", bus.out_valid); end
    tests++; if (bus.sum !== 32'h0) begin fails++; $display("FAIL add_wrap sum got %h want 0", bus.sum); end
    tests++; if ({bus.c_out, bus.ovf, bus.zero} !== 3'b101) begin fails++; $display("FAIL add_wrap c/o/z got %b want 101", {bus.c_out, bus.ovf, bus.zero}); end
    send(1'b0, 32'h10, 32'h20, 1'b1);
    @(posedge clk); #1;
    tests++; if (bus.sum !== 32'h31) begin fails++; $display("FAIL add_cin sum got %h want 31", bus.sum); end
    tests++; if ({bus.c_out, bus.ovf, bus.zero} !== 3'b000) begin fails++; $display("FAIL add_cin c/o/z got %b want 000", {bus.c_out, bus.ovf, bus.zero}); end
  endtask

  task automatic test_sub;
    send(1'b1, 32'h5, 32'h7, 1'b0);
    @(posedge clk); #1;
    tests++; if (bus.sum !== 32'hFFFFFFFE) begin fails++; $display("FAIL sub_neg sum got %h want fffffffe", bus.sum); end
    tests++; if ({bus.c_out, bus.ovf, bus.zero} !== 3'b000) begin fails++; $display("FAIL sub_neg c/o/z got %b want 000", {bus.c_out, bus.ovf, bus.zero}); end
    send(1'b1, 32'h7, 32'h5, 1'b1);
    @(posedge clk); #1;
    tests++; if (bus.sum !== 32'h1) begin fails++; $display("FAIL sub_bin sum got %h want 1", bus.sum); end
    tests++; if ({bus.c_out, bus.ovf, bus.zero} !== 3'b100) begin fails++; $display("FAIL sub_bin c/o/z got %b want 100", {bus.c_out, bus.ovf, bus.zero}); end
  endtask

  task automatic test_ovf;
    send(1'b0, 32'h7FFFFFFF, 32'h1, 1'b0);
    @(posedge clk); #1;
    tests++; if (bus.sum !== 32'h80000000) begin fails++; $display("FAIL ovf_add sum got %h want 80000000", bus.sum); end
    tests++; if ({bus.c_out, bus.ovf, bus.zero} !== 3'b010) begin fails++; $display("FAIL ovf_add c/o/z got %b want 010", {bus.c_out, bus.ovf, bus.zero}); end
    send(1'b1, 32'h80000000, 32'h1, 1'b0);
    @(posedge clk); #1;
    tests++; if (bus.sum !== 32'h7FFFFFFF) begin fails++; $display("FAIL ovf_sub sum got %h want 7fffffff", bus.sum); end
    tests++; if ({bus.c_out, bus.ovf, bus.zero} !== 3'b110) begin fails++; $display("FAIL ovf_sub c/o/z got %b want 110", {bus.c_out, bus.ovf, bus.zero}); end
  endtask

  task automatic test_slice_carry;
    send(1'b0, 32'h0000FFFF, 32'h1, 1'b0);
    @(posedge clk); #1;
    tests++; if (bus.sum !== 32'h00010000) begin fails++; $display("FAIL slice_carry sum got %h want 00010000", bus.sum); end
    tests++; if ({bus.c_out, bus.ovf, bus.zero} !== 3'b000) begin fails++; $display("FAIL slice_carry c/o/z got %b want 000", {bus.c_out, bus.ovf, bus.zero}); end
  endtask

  task automatic test_back_to_back;
    int nv;
    nv = 0;
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) begin
        bus.in_valid = 1'b1;
        bus.op_sub   = bb_op[i];
        bus.a        = bb_a[i];
        bus.b        = bb_b[i];
        bus.c_in     = bb_ci[i];
      end else begin
        bus.in_valid = 1'b0;
      end
      @(posedge clk); #1;
      if (i >= 1) begin
        if (bus.out_valid === 1'b1) nv++;
        tests++; if (bus.out_valid !== 1'b1 || bus.sum !== bb_s[i-1] || bus.c_out !== bb_co[i-1]) begin
          fails++; $display("FAIL b2b[%0d] got v=%b s=%h c=%b want v=1 s=%h c=%b", i - 1, bus.out_valid, bus.sum, bus.c_out, bb_s[i-1], bb_co[i-1]);
        end
      end
    end
    tests++; if (nv != 8) begin fails++; $display("FAIL b2b_count got %0d want 8", nv); end
    @(posedge clk); #1;
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL b2b_drain out_valid got %b want 0", bus.out_valid); end
  endtask

  task automatic test_backpressure;
    logic [31:0] exp_s [4];
    int sent;
    int got;
    exp_s = '{32'h2, 32'h4, 32'h6, 32'h8};
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
      bus.out_ready = (cyc >= 6);
      bus.op_sub    = 1'b0;
      bus.c_in      = 1'b0;
      if (sent < 4) begin
        bus.in_valid = 1'b1;
        bus.a        = 32'(sent + 1);
        bus.b        = 32'(sent + 1);
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (cyc == 5) begin
        tests++; if (sent != 2) begin fails++; $display("FAIL bp_accepted got %0d want 2", sent); end
        tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready got %b want 0", bus.in_ready); end
      end
      if (cyc >= 2 && cyc <= 5) begin
        tests++; if (bus.out_valid !== 1'b1 || bus.sum !== 32'h2) begin
          fails++; $display("FAIL bp_hold cyc %0d got v=%b s=%h want v=1 s=2", cyc, bus.out_valid, bus.sum);
        end
      end
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        tests++; if (bus.sum !== exp_s[got]) begin fails++; $display("FAIL bp_out[%0d] got %h want %h", got, bus.sum, exp_s[got]); end
        got++;
      end
      if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) sent++;
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tests++; if (got != 4) begin fails++; $display("FAIL bp_count got %0d want 4", got); end
    #1;
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL bp_dup out_valid got %b want 0", bus.out_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    bus.in_valid = 1'b1;
    bus.op_sub   = 1'b0;
    bus.c_in     = 1'b0;
    bus.a        = 32'd10;
    bus.b        = 32'd20;
    @(posedge clk); #1;
    bus.a = 32'd1;
    bus.b = 32'd1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rmid out_valid got %b want 0", bus.out_valid); end
    tests++; if (bus.sum !== 32'h0) begin fails++; $display("FAIL rmid sum got %h want 0", bus.sum); end
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL rmid in_ready got %b want 1", bus.in_ready); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rmid_flush out_valid got %b want 0", bus.out_valid); end
    send(1'b0, 32'd3, 32'd4, 1'b0);
    @(posedge clk); #1;
    tests++; if (bus.out_valid !== 1'b1 || bus.sum !== 32'd7) begin
      fails++; $display("FAIL rmid_new got v=%b s=%h want v=1 s=7", bus.out_valid, bus.sum);
    end
  endtask

  initial begin
    tests         = 0;
    fails         = 0;
    clk           = 1'b0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op_sub    = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.c_in      = 1'b0;
    bus.out_ready = 1'b1;
    test_reset();
    test_add();
    test_sub();
    test_ovf();
    test_slice_carry();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
